pmod_hexpad: RTL and testbench

PMOD_HEXPAD -- requirements
Module: pmod_hexpad

---
 rtl/pmod_hexpad.sv | 95 +++++++++
 tb/tb_pmod_hexpad.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pmod_hexpad.sv
`default_nettype none
// =============================================================================
// pmod_hexpad : column-scanning decoder for a PmodKYPD 4x4 hex keypad
// Rev 1.0 -- initial release
// =============================================================================
module pmod_hexpad #(
    parameter int COL_PERIOD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] value_out
);

    localparam logic [19:0] c_LAST = 20'(COL_PERIOD - 1);

    logic [19:0] counter, counter_d;
    logic [15:0] value, value_d;
    logic [15:0] value_out_q, value_out_d;
    logic [1:0]  col_idx_q, col_idx_d;
    logic [3:0]  sync1_q, sync2_q;
    logic        w_sample;
    logic [15:0] w_hits;

    // Hex key located at (column c, row index r) on the keypad face.
    function automatic logic [3:0] key_at(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] k;
        case ({c, r})
            4'h0: k = 4'h1;  4'h1: k = 4'h4;  4'h2: k = 4'h7;  4'h3: k = 4'h0;
            4'h4: k = 4'h2;  4'h5: k = 4'h5;  4'h6: k = 4'h8;  4'h7: k = 4'hF;
            4'h8: k = 4'h3;  4'h9: k = 4'h6;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
            4'hC: k = 4'hA;  4'hD: k = 4'hB;  4'hE: k = 4'hC;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign w_sample  = (counter == c_LAST);
    assign value_out = value_out_q;

    always_comb begin
        case (col_idx_q)
            2'd0:    col = 4'b0111;
            2'd1:    col = 4'b1011;
            2'd2:    col = 4'b1101;
            default: col = 4'b1110;
        endcase
    end

    // Row bit (3-r) low means the key at row index r of the driven column is down.
    always_comb begin
        w_hits = '0;
        for (int r = 0; r < 4; r++) begin
            if (!sync2_q[3-r]) begin
                w_hits[key_at(col_idx_q, 2'(r))] = 1'b1;
            end
        end
    end

    always_comb begin
        counter_d   = w_sample ? '0 : counter + 20'd1;
        col_idx_d   = w_sample ? col_idx_q + 2'd1 : col_idx_q;
        value_d     = value;
        value_out_d = value_out_q;
        if (w_sample) begin
            if (col_idx_q == 2'd3) begin
                // Publish the frame including this last column, start a fresh one.
                value_out_d = value | w_hits;
                value_d     = '0;
            end else begin
                value_d = value | w_hits;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter     <= '0;
            col_idx_q   <= '0;
            value       <= '0;
            value_out_q <= '0;
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
        end else begin
            counter     <= counter_d;
            col_idx_q   <= col_idx_d;
            value       <= value_d;
            value_out_q <= value_out_d;
            sync1_q     <= row;
            sync2_q     <= sync1_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmod_hexpad.sv
`default_nettype none
// =============================================================================
// tb_pmod_hexpad : randomized keypad presses against a frame-level reference
// Rev 1.0 -- initial release
// =============================================================================
module tb_pmod_hexpad;

    localparam int P = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] value_out;
    logic [15:0] keys = 16'h0000;

    int checks   = 0;
    int failures = 0;

    // Keypad face: index c*4+r -> hex key
    int km [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    pmod_hexpad #(.COL_PERIOD(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .value_out (value_out)
    );

    always #5 clk = ~clk;

    // Physical keypad: a held key shorts its row line to the driven column.
    function automatic logic [3:0] pad_rows(input logic [3:0] c, input logic [15:0] k);
        logic [3:0] r;
        int ci;
        r  = 4'hF;
        ci = -1;
        case (c)
            4'b0111: ci = 0;
            4'b1011: ci = 1;
            4'b1101: ci = 2;
            4'b1110: ci = 3;
            default: ci = -1;
        endcase
        if (ci >= 0) begin
            for (int i = 0; i < 4; i++) begin
                if (k[km[ci*4+i]]) r[3-i] = 1'b0;
            end
        end
        return r;
    endfunction

    assign row = pad_rows(col, keys);

    // Reference: edges since release, a two-deep row history, frame accumulator.
    int          e       = 0;
    logic [3:0]  rh1     = 4'hF;
    logic [3:0]  rh2     = 4'hF;
    logic [15:0] acc     = 16'h0;
    logic [15:0] exp_out = 16'h0;
    logic [3:0]  exp_col;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e = 0; rh1 = 4'hF; rh2 = 4'hF; acc = 16'h0; exp_out = 16'h0;
        end else begin
            if (e % P == P - 1) begin
                int c;
                c = (e / P) % 4;
                for (int r = 0; r < 4; r++) begin
                    if (!rh2[3-r]) acc[km[c*4+r]] = 1'b1;
                end
                if (c == 3) begin
                    exp_out = acc;
                    acc     = 16'h0;
                end
            end
            rh2 = rh1;
            rh1 = row;
            e   = e + 1;
        end
    end

    always_comb exp_col = ~(4'b1000 >> ((e / P) % 4));

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cycle_value_out", value_out, exp_out);
        check("cycle_col", {12'h0, col}, {12'h0, exp_col});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        keys  = 16'h0000;
        cycles(3);
        check("reset_value_out", value_out, 16'h0000);
        check("reset_col", {12'h0, col}, 16'h0007);

        // Idle scan: column walk with no key
        reset = 1'b1;
        cycles(P);
        check("idle_col1", {12'h0, col}, 16'h000B);
        cycles(P);
        check("idle_col2", {12'h0, col}, 16'h000D);
        cycles(P);
        check("idle_col3", {12'h0, col}, 16'h000E);
        cycles(P);
        check("idle_frame", value_out, 16'h0000);

        // Key 4 from a clean release: first update exactly one frame in
        reset = 1'b0;
        cycles(1);
        keys  = 16'h0010;
        reset = 1'b1;
        cycles(4*P - 1);
        check("key4_before_frame", value_out, 16'h0000);
        cycles(1);
        check("key4_frame1", value_out, 16'h0010);
        check("key4_model", exp_out, 16'h0010);
        cycles(4*P);
        check("key4_frame2", value_out, 16'h0010);

        keys = 16'h0000;
        cycles(4*P);
        check("key4_released", value_out, 16'h0000);

        keys = 16'h2002;
        cycles(4*P);
        check("keys_1_D", value_out, 16'h2002);
        check("keys_1_D_model", exp_out, 16'h2002);

        // Mid-frame reset with keys still held
        cycles(P + 3);
        #2 reset = 1'b0;
        #1;
        check("midreset_value_out", value_out, 16'h0000);
        check("midreset_col", {12'h0, col}, 16'h0007);
        cycles(2);
        reset = 1'b1;
        cycles(4*P - 1);
        check("post_reset_hold", value_out, 16'h0000);
        cycles(1);
        check("post_reset_frame", value_out, 16'h2002);

        // Randomized presses, occasional mid-run resets
        for (int it = 0; it < 60; it++) begin
            int n;
            n    = $urandom_range(0, 3);
            keys = 16'h0000;
            for (int j = 0; j < n; j++) keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 14) == 0) begin
                #2 reset = 1'b0;
                cycles($urandom_range(1, 3));
                reset = 1'b1;
            end
            cycles($urandom_range(4, 100));
        end

        keys = 16'h8421;
        cycles(8*P);
        check("final_diag", value_out, 16'h8421);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
